// File: rtl/fir_serial_ctrl_pkg.sv
// fir_serial_ctrl shared definitions
// FSM states, default sizing and counter width helper
package fir_serial_ctrl_pkg;

  localparam int DEF_ORDER      = 7;
  localparam int DEF_COEFF_NUM  = DEF_ORDER + 1;
  localparam int DEF_DIN_BITS   = 16;
  localparam int DEF_COEFF_BITS = 16;
  localparam int DEF_DOUT_BITS  = 40;
  localparam int DEF_ADDR_BITS  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  // RUN counter must hold ORDER
  function automatic int cnt_bits(input int order);
    return (order < 1) ? 1 : $clog2(order + 1);
  endfunction

endpackage

// File: rtl/fir_serial_ctrl_if.sv
// fir_serial_ctrl bus bundle
// sample/result handshakes, config, status and engine side
interface fir_serial_ctrl_if
  import fir_serial_ctrl_pkg::*;
#(
  parameter int DIN_BITS   = DEF_DIN_BITS,
  parameter int COEFF_BITS = DEF_COEFF_BITS,
  parameter int DOUT_BITS  = DEF_DOUT_BITS,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int COEFF_NUM  = DEF_COEFF_NUM
) ();

  logic                            en;
  logic [DIN_BITS-1:0]             din;
  logic                            din_valid;
  logic                            din_ready;
  logic [DOUT_BITS-1:0]            dout;
  logic                            dout_valid;
  logic                            dout_ready;
  logic                            cfg_wr;
  logic [ADDR_BITS-1:0]            cfg_addr;
  logic [COEFF_BITS-1:0]           cfg_wdata;
  logic                            cfg_commit;
  logic                            commit_pending;
  logic                            sts_clr;
  logic                            overrun;
  logic                            fir_clken;
  logic [DIN_BITS-1:0]             fir_data_in;
  logic [COEFF_NUM*COEFF_BITS-1:0] fir_k;
  logic [DOUT_BITS-1:0]            fir_data_out;
  logic                            fir_valid;

  modport slave (
    input  en, din, din_valid, dout_ready,
    input  cfg_wr, cfg_addr, cfg_wdata,
    input  cfg_commit, sts_clr,
    input  fir_data_out, fir_valid,
    output din_ready, dout, dout_valid,
    output commit_pending, overrun,
    output fir_clken, fir_data_in, fir_k
  );

  modport master (
    output en, din, din_valid, dout_ready,
    output cfg_wr, cfg_addr, cfg_wdata,
    output cfg_commit, sts_clr,
    output fir_data_out, fir_valid,
    input  din_ready, dout, dout_valid,
    input  commit_pending, overrun,
    input  fir_clken, fir_data_in, fir_k
  );

endinterface

// File: rtl/fir_serial_ctrl_coeff_bank.sv
// fir_coeff_bank: shadow/active coefficient store
// swap copies pre-write shadow into active
module fir_coeff_bank #(
  parameter int COEFF_NUM  = 8,
  parameter int COEFF_BITS = 16,
  parameter int ADDR_BITS  = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_i,
  input  logic [ADDR_BITS-1:0]            addr_i,
  input  logic [COEFF_BITS-1:0]           wdata_i,
  input  logic                            swap_i,
  output logic [COEFF_NUM*COEFF_BITS-1:0] k_o
);

  logic [COEFF_BITS-1:0] shd_q [COEFF_NUM];
  logic [COEFF_BITS-1:0] shd_d [COEFF_NUM];
  logic [COEFF_BITS-1:0] act_q [COEFF_NUM];
  logic [COEFF_BITS-1:0] act_d [COEFF_NUM];

  // out-of-range addresses match no entry
  always_comb begin
    shd_d = shd_q;
    act_d = act_q;
    if (swap_i) act_d = shd_q;
    for (int i = 0; i < COEFF_NUM; i++) begin
      if (wr_i && (int'(addr_i) == i)) shd_d[i] = wdata_i;
    end
  end

  // bank registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shd_q <= '{default: '0};
      act_q <= '{default: '0};
    end else begin
      shd_q <= shd_d;
      act_q <= act_d;
    end
  end

  // flatten active bank, k0 in LSBs
  always_comb begin
    k_o = '0;
    for (int i = 0; i < COEFF_NUM; i++) begin
      k_o[i*COEFF_BITS +: COEFF_BITS] = act_q[i];
    end
  end

endmodule

// File: rtl/fir_serial_ctrl.sv
// fir_serial_ctrl: sequencer for a serial FIR engine
// sample handshake, clken FSM, result path, status
module fir_serial_ctrl
  import fir_serial_ctrl_pkg::*;
#(
  parameter int ORDER      = DEF_ORDER,
  parameter int COEFF_NUM  = DEF_COEFF_NUM,
  parameter int DIN_BITS   = DEF_DIN_BITS,
  parameter int COEFF_BITS = DEF_COEFF_BITS,
  parameter int DOUT_BITS  = DEF_DOUT_BITS,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input logic              clk,
  input logic              reset,
  fir_serial_ctrl_if.slave bus
);

  localparam int CW = cnt_bits(ORDER);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DIN_BITS-1:0]  din_q;
  logic                 pend_q, pend_d;
  logic                 primed_q, primed_d;
  logic                 dv_q, dv_d;
  logic                 ovr_q, ovr_d;
  logic [DOUT_BITS-1:0] dout_q, dout_d;
  logic                 ready;
  logic                 accept;
  logic                 swap;
  logic                 load;

  assign ready  = reset & bus.en & (state_q == S_IDLE);
  assign accept = ready & bus.din_valid;
  assign swap   = accept & (pend_q | bus.cfg_commit);
  assign load   = bus.fir_valid & primed_q;

  // state and RUN counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // IDLE -> FIRE (1 cycle) -> RUN (ORDER+1 cycles)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_FIRE;
      S_FIRE: begin
        state_d = S_RUN;
        cnt_d   = CW'(ORDER);
      end
      S_RUN: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // commit pending and result path next state
  always_comb begin
    pend_d   = pend_q;
    primed_d = primed_q;
    dv_d     = dv_q;
    dout_d   = dout_q;
    ovr_d    = ovr_q;
    if (swap) pend_d = 1'b0;
    else if (bus.cfg_commit) pend_d = 1'b1;
    if (bus.fir_valid && !primed_q) primed_d = 1'b1;
    if (load) begin
      dout_d = bus.fir_data_out;
      dv_d   = 1'b1;
    end else if (bus.dout_ready) begin
      dv_d   = 1'b0;
    end
    if (bus.sts_clr) ovr_d = 1'b0;
    if (load && dv_q && !bus.dout_ready) ovr_d = 1'b1;
  end

  // sample latch, commit and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din_q    <= '0;
      pend_q   <= 1'b0;
      primed_q <= 1'b0;
      dv_q     <= 1'b0;
      dout_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (accept) din_q <= bus.din;
      pend_q   <= pend_d;
      primed_q <= primed_d;
      dv_q     <= dv_d;
      dout_q   <= dout_d;
      ovr_q    <= ovr_d;
    end
  end

  fir_coeff_bank #(
    .COEFF_NUM  (COEFF_NUM),
    .COEFF_BITS (COEFF_BITS),
    .ADDR_BITS  (ADDR_BITS)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (bus.cfg_wr),
    .addr_i  (bus.cfg_addr),
    .wdata_i (bus.cfg_wdata),
    .swap_i  (swap),
    .k_o     (bus.fir_k)
  );

  assign bus.din_ready      = ready;
  assign bus.fir_clken      = (state_q == S_FIRE);
  assign bus.fir_data_in    = din_q;
  assign bus.commit_pending = pend_q;
  assign bus.dout           = dout_q;
  assign bus.dout_valid     = dv_q;
  assign bus.overrun        = ovr_q;

endmodule

// File: doc/fir_serial_ctrl.md
Name: fir_serial_ctrl

Overview:
- Sequencer and configuration controller for one fir_serial engine. Accepts input samples over a valid/ready handshake and holds each sample stable for a full serial pass. Issues the engine's clken strobe and forwards engine results over a valid/ready output.
- Owns a double-buffered coefficient store: software writes the shadow bank, and a commit copies it to the active bank exactly at a sample boundary.

Parameters:
- ORDER, 7, filter order; one serial pass takes ORDER+1 cycles.
- COEFF_NUM, 8, number of coefficients (ORDER+1).
- DIN_BITS, 16, input sample width.
- COEFF_BITS, 16, coefficient width.
- DOUT_BITS, 40, engine output width.
- ADDR_BITS, 3, coefficient address width (ceil log2 COEFF_NUM).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- en  in  1  enable; low blocks new sample acceptance.
- din  in  DIN_BITS  input sample.
- din_valid  in  1  sample offered.
- din_ready  out  1  controller can accept a sample.
- dout  out  DOUT_BITS  filtered result.
- dout_valid  out  1  result held.
- dout_ready  in  1  downstream takes result.
- cfg_wr  in  1  shadow coefficient write strobe.
- cfg_addr  in  ADDR_BITS  coefficient index.
- cfg_wdata  in  COEFF_BITS  coefficient value.
- cfg_commit  in  1  request shadow-to-active copy.
- commit_pending  out  1  commit requested, not yet applied.
- sts_clr  in  1  clear sticky status.
- overrun  out  1  sticky: result lost to backpressure.
- fir_clken  out  1  engine clken.
- fir_data_in  out  DIN_BITS  engine data_in.
- fir_k  out  COEFF_NUM*COEFF_BITS  active coefficients, k0 in LSBs.
- fir_data_out  in  DOUT_BITS  engine data_out.
- fir_valid  in  1  engine valid.

Behaviour:
- Reset values: all outputs 0 except din_ready, which is 0 during reset and 1 after. Both coefficient banks 0; the primed flag is cleared.
- States:
  - IDLE: din_ready = en.
  - FIRE: 1 cycle, fir_clken=1.
  - RUN: ORDER+1 cycles, counter counts down; then IDLE.
- Accept happens when din_valid & din_ready in cycle T:
  - din is latched into fir_data_in.
  - FIRE occurs in T+1.
  - RUN spans T+2..T+ORDER+2.
  - IDLE is reached at T+ORDER+3.
  - Minimum sample spacing is ORDER+3 cycles.
- fir_data_in changes only on accept; it is stable for all of FIRE and RUN.
- Commit:
  - cfg_commit sets commit_pending.
  - On the next accept, the active bank takes the shadow contents and commit_pending clears. The new fir_k is therefore visible from T+1, together with fir_clken.
  - If cfg_commit and an accept occur in the same cycle, the swap is applied in that cycle.
- Shadow writes:
  - cfg_wr writes the shadow bank only.
  - Writes with cfg_addr >= COEFF_NUM are ignored.
  - If cfg_wr coincides with a swap, the written value stays in the shadow and the active bank gets the pre-write shadow contents.
- Result forwarding:
  - The engine emits fir_valid the cycle after fir_clken; each result belongs to the previous sample.
  - The first fir_valid after reset carries no sample; it is discarded and sets primed.
  - Subsequent fir_valid pulses load dout and set dout_valid.
  - dout_valid clears on dout_ready unless a new result loads in the same cycle; a same-cycle load wins.
- Overrun: if fir_valid arrives (primed) while dout_valid & !dout_ready, dout is overwritten with the new result and overrun sets. sts_clr clears overrun; a same-cycle set wins.
- en deasserted mid-pass: the current FIRE/RUN completes and no new accept occurs.
- Reset asserted mid-pass: the pass aborts immediately and all state returns to reset values.

Decomposition:
- Shared include file fir_serial_ctrl_defs holds:
  - state encodings (IDLE, FIRE, RUN);
  - the RUN counter width as a function of ORDER.
- Sub-module fir_coeff_bank holds the shadow and active registers, the write decode, the swap logic and the flattened fir_k output.
- The FSM, the handshakes and the result path stay in the top level.

Test Plan:
- Basic timing: after reset, hold din_valid=1, din=0x0100, en=1 → accept at T, fir_clken high only at T+1, din_ready low T+1..T+9 (ORDER=7), next accept at T+10; first fir_valid is discarded; the second result appears on dout with dout_valid.
- Coefficient commit: write shadow k0..k7=1..8, pulse cfg_commit while IDLE → commit_pending=1 and fir_k stays 0 until the next accept; fir_k=1..8 from T+1 and commit_pending=0.
- Write/swap collision: cfg_wr addr 2 data 0x55 in the same cycle as an accept with commit pending → active k2 keeps the old shadow value; a second commit plus accept gives k2=0x55. A write with addr 7 is applied; with ADDR_BITS widened to 4 and addr 9, the write is ignored.
- Backpressure: dout_ready=0 over two consecutive results → dout holds the second result and overrun=1; sts_clr → overrun=0; dout_ready=1 → dout_valid drops next cycle.
- Enable gating: drop en during RUN → the pass completes, din_ready stays 0, no further fir_clken; raise en → din_ready=1 and acceptance resumes.
- Reset mid-pass: assert reset in RUN cycle 3 → fir_clken=0, dout_valid=0, fir_k=0, primed cleared; after release, the first result is discarded again.
